pll_lock_supervisor: RTL and testbench

//  Consumer side of the PLL rst/locked interface. Sits in the refclk domain next to the PLL wrapper.

---
 rtl/pll_lock_supervisor.sv | 71 +++++++
 tb/tb_pll_lock_supervisor.sv | 114 +++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: drives PLL reset, synchronises lock, releases system reset after stable lock
module pll_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 64,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 5000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             soft_reset_req,
  output logic             pll_rst,
  output logic             sys_reset_n,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] lock_lost_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);
  localparam int MAXC = (PLL_RST_CYCLES > LOCK_TIMEOUT)
                        ? ((PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES)
                        : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN} state_e;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pll_rst_q, sys_reset_n_q;
  logic [CNT_W-1:0]       lost_q, lost_d, to_q, to_d;
  logic                   locked_s, to_hit, lost_hit;
  assign locked_s = sync_q[SYNC_STAGES-1];
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_PLL: state_d = (cnt_q == CW'(PLL_RST_CYCLES-1)) ? WAIT_LOCK : RESET_PLL;
      WAIT_LOCK: state_d = locked_s ? STABLE : (cnt_q == CW'(LOCK_TIMEOUT-1)) ? RESET_PLL : WAIT_LOCK;
      STABLE:    state_d = !locked_s ? WAIT_LOCK : (cnt_q == CW'(STABLE_CYCLES-1)) ? RUN : STABLE;
      RUN:       state_d = locked_s ? RUN : RESET_PLL;
    endcase
    to_hit   = !soft_reset_req && state_q == WAIT_LOCK && state_d == RESET_PLL;
    lost_hit = !soft_reset_req && state_q == RUN && state_d == RESET_PLL;
    if (soft_reset_req) state_d = RESET_PLL;
    // the counter idles in RUN so it never wraps while the system runs
    cnt_d  = (soft_reset_req || state_d != state_q) ? '0 : cnt_q + CW'(state_q != RUN);
    to_d   = to_q + CNT_W'(to_hit && !(&to_q));
    lost_d = lost_q + CNT_W'(lost_hit && !(&lost_q));
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= RESET_PLL;
      cnt_q         <= '0;
      sync_q        <= '0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      lost_q        <= '0;
      to_q          <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync_q        <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      pll_rst_q     <= state_d == RESET_PLL;
      sys_reset_n_q <= state_d == RUN;
      lost_q        <= lost_d;
      to_q          <= to_d;
    end
  end
  assign pll_rst       = pll_rst_q;
  assign sys_reset_n   = sys_reset_n_q;
  assign state         = state_q;
  assign lock_lost_cnt = lost_q;
  assign timeout_cnt   = to_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed checks of reset sequencing, timeouts, glitches, lock loss and soft reset
module tb_pll_lock_supervisor;
  logic       clk = 1'b0, reset_n = 1'b0, pll_locked = 1'b0, soft_reset_req = 1'b0;
  logic       pll_rst, sys_reset_n;
  logic [1:0] state;
  logic [3:0] lock_lost_cnt, timeout_cnt;
  int         n_vec = 0, n_err = 0;
  pll_lock_supervisor #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(10), .CNT_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .soft_reset_req(soft_reset_req),
    .pll_rst(pll_rst), .sys_reset_n(sys_reset_n), .state(state),
    .lock_lost_cnt(lock_lost_cnt), .timeout_cnt(timeout_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk_all(input string tag, input int st, input int pr, input int sr, input int ll, input int tc);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".pll_rst"}, 32'(pll_rst), 32'(pr));
    chk({tag, ".sys_reset_n"}, 32'(sys_reset_n), 32'(sr));
    chk({tag, ".lock_lost"}, 32'(lock_lost_cnt), 32'(ll));
    chk({tag, ".timeout"}, 32'(timeout_cnt), 32'(tc));
  endtask
  initial begin
    tick(2);
    chk_all("reset", 0, 1, 0, 0, 0);
    reset_n = 1'b1;
    tick(3);
    chk_all("rst_hold", 0, 1, 0, 0, 0);
    tick(1);
    chk_all("wait_entry", 1, 0, 0, 0, 0);
    tick(4);
    pll_locked = 1'b1;
    tick(2);
    chk("sync_delay", 32'(state), 32'd1);
    tick(1);
    chk("stable_entry", 32'(state), 32'd2);
    tick(9);
    chk_all("stable_last", 2, 0, 0, 0, 0);
    tick(1);
    chk_all("run_entry", 3, 0, 1, 0, 0);
    pll_locked = 1'b0;
    tick(2);
    chk_all("run_sync_lag", 3, 0, 1, 0, 0);
    tick(1);
    chk_all("lock_lost", 0, 1, 0, 1, 0);
    pll_locked = 1'b1;
    tick(4);
    chk("relock_wait", 32'(state), 32'd1);
    tick(1);
    chk("relock_stable", 32'(state), 32'd2);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(2);
    chk_all("glitch", 1, 0, 0, 1, 0);
    tick(1);
    chk("glitch_restable", 32'(state), 32'd2);
    tick(9);
    chk("glitch_restart", 32'(state), 32'd2);
    tick(1);
    chk_all("glitch_run", 3, 0, 1, 1, 0);
    pll_locked = 1'b0;
    tick(2);
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    chk_all("soft_vs_lost", 0, 1, 0, 1, 0);
    tick(2);
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    tick(3);
    chk_all("soft_rehold", 0, 1, 0, 1, 0);
    tick(1);
    chk_all("soft_wait", 1, 0, 0, 1, 0);
    tick(19);
    chk_all("to_last", 1, 0, 0, 1, 0);
    tick(1);
    chk_all("to_1", 0, 1, 0, 1, 1);
    tick(3);
    chk("to_rst_hold", 32'(pll_rst), 32'd1);
    tick(1);
    chk("to_rst_end", 32'(pll_rst), 32'd0);
    tick(20);
    chk_all("to_2", 0, 1, 0, 1, 2);
    tick(24);
    chk_all("to_3", 0, 1, 0, 1, 3);
    for (int i = 4; i <= 20; i++) begin
      tick(24);
      chk_all($sformatf("to_%0d", i), 0, 1, 0, 1, (i > 15) ? 15 : i);
    end
    tick(9);
    chk_all("pre_reset", 1, 0, 0, 1, 15);
    reset_n = 1'b0;
    tick(1);
    chk_all("mid_reset", 0, 1, 0, 0, 0);
    reset_n = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
